multicycle_ctrl: RTL and testbench

- Multi-cycle control sequencer for the 8-bit Microprocessor datapath (PC, IMEM, 4x8 register file, ALU, data memory, DIS1/DIS2 display).
- Replaces the single-cycle decode with a Moore FSM that drives the datapath enables one phase per clock.
- Adds run / single-step debug control and a retired-instruction counter that feeds the seven-segment display.

---
 rtl/mp_pkg.sv | 41 ++++
 rtl/multicycle_ctrl_if.sv | 34 +++
 rtl/multicycle_ctrl_decode.sv | 47 ++++
 rtl/multicycle_ctrl.sv | 94 +++++++++
 tb/tb_multicycle_ctrl.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/mp_pkg.sv
// Shared definitions for the multi-cycle microprocessor controller:
// FSM state codes, opcodes, instruction field positions and the control-strobe bundle.
package mp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_LW  = 2'b01,
    OP_SW  = 2'b10,
    OP_J   = 2'b11
  } opcode_t;

  localparam int OPCODE_MSB = 7;
  localparam int OPCODE_LSB = 6;

  typedef struct packed {
    logic irLoad;
    logic pcWrite;
    logic pcSrc;
    logic aluSrc;
    logic memRead;
    logic memWrite;
    logic regWrite;
    logic regDst;
    logic memToReg;
    logic instrDone;
  } ctrl_t;

  function automatic opcode_t getOpcode(input logic [7:0] instr);
    return opcode_t'(instr[OPCODE_MSB:OPCODE_LSB]);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Bundle between the controller (master) and the datapath/debug side (slave):
// debug inputs and fetched instruction in, datapath strobes and status out.
interface multicycle_ctrl_if #(
  parameter int RET_W = 8
);
  logic             RUN;
  logic             STEP;
  logic [7:0]       INSTR;
  logic             IR_LOAD;
  logic             PC_WRITE;
  logic             PC_SRC;
  logic             ALU_SRC;
  logic             MEM_READ;
  logic             MEM_WRITE;
  logic             REG_WRITE;
  logic             REG_DST;
  logic             MEM_TO_REG;
  logic [2:0]       STATE;
  logic             BUSY;
  logic             INSTR_DONE;
  logic [RET_W-1:0] RETIRED;

  modport master (
    input  RUN, STEP, INSTR,
    output IR_LOAD, PC_WRITE, PC_SRC, ALU_SRC, MEM_READ, MEM_WRITE,
           REG_WRITE, REG_DST, MEM_TO_REG, STATE, BUSY, INSTR_DONE, RETIRED
  );

  modport slave (
    output RUN, STEP, INSTR,
    input  IR_LOAD, PC_WRITE, PC_SRC, ALU_SRC, MEM_READ, MEM_WRITE,
           REG_WRITE, REG_DST, MEM_TO_REG, STATE, BUSY, INSTR_DONE, RETIRED
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational Moore decode from (state, latched opcode) to the datapath strobe bundle.
module ctrl_decode
  import mp_pkg::*;
(
  input  state_t  i_state,
  input  opcode_t i_opcode,
  output ctrl_t   o_ctrl
);

  always_comb begin
    o_ctrl = '0;
    case (i_state)
      ST_FETCH: begin
        o_ctrl.irLoad  = 1'b1;
        o_ctrl.pcWrite = 1'b1;
      end
      ST_DECODE: begin
        if (i_opcode == OP_J) begin
          o_ctrl.pcWrite   = 1'b1;
          o_ctrl.pcSrc     = 1'b1;
          o_ctrl.instrDone = 1'b1;
        end
      end
      ST_EXEC: begin
        o_ctrl.aluSrc = (i_opcode == OP_LW) || (i_opcode == OP_SW);
      end
      ST_MEM: begin
        // LW keeps the address operand selected while the read is in flight
        if (i_opcode == OP_LW) begin
          o_ctrl.memRead = 1'b1;
          o_ctrl.aluSrc  = 1'b1;
        end else if (i_opcode == OP_SW) begin
          o_ctrl.memWrite  = 1'b1;
          o_ctrl.instrDone = 1'b1;
        end
      end
      ST_WB: begin
        o_ctrl.regWrite  = 1'b1;
        o_ctrl.instrDone = 1'b1;
        o_ctrl.regDst    = (i_opcode == OP_ADD);
        o_ctrl.memToReg  = (i_opcode == OP_LW);
      end
      default: o_ctrl = '0;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control sequencer: phase FSM with run/single-step debug control
// and a retired-instruction counter. All strobes come straight from registers.
module multicycle_ctrl
  import mp_pkg::*;
#(
  parameter bit AUTO_RUN = 1'b1,
  parameter int RET_W    = 8
) (
  input logic              CLK,
  input logic              RST,
  multicycle_ctrl_if.master bus
);

  state_t           r_state;
  state_t           w_nextState;
  state_t           w_endState;
  opcode_t          r_opcode;
  opcode_t          w_nextOpcode;
  logic             r_stepMode;
  logic             w_nextStepMode;
  logic [RET_W-1:0] r_retired;
  ctrl_t            r_ctrl;
  ctrl_t            w_nextCtrl;
  logic             r_busy;
  logic             w_run;
  logic             w_unusedFields;

  assign w_run          = AUTO_RUN | bus.RUN;
  assign w_unusedFields = ^bus.INSTR[OPCODE_LSB-1:0];
  assign w_endState     = (w_run && !r_stepMode) ? ST_FETCH : ST_IDLE;

  always_comb begin
    w_nextState    = r_state;
    w_nextOpcode   = r_opcode;
    w_nextStepMode = r_stepMode;
    case (r_state)
      ST_IDLE: begin
        if (w_run || bus.STEP) begin
          w_nextState    = ST_FETCH;
          w_nextStepMode = !w_run;
        end
      end
      ST_FETCH: begin
        w_nextState  = ST_DECODE;
        w_nextOpcode = getOpcode(bus.INSTR);
      end
      ST_DECODE: w_nextState = (r_opcode == OP_J) ? w_endState : ST_EXEC;
      ST_EXEC:   w_nextState = (r_opcode == OP_ADD) ? ST_WB : ST_MEM;
      ST_MEM:    w_nextState = (r_opcode == OP_LW) ? ST_WB : w_endState;
      ST_WB:     w_nextState = w_endState;
      default:   w_nextState = ST_IDLE;
    endcase
  end

  // Decoding the next state lets the strobes be registered yet still line up with STATE
  ctrl_decode u_decode (
    .i_state  (w_nextState),
    .i_opcode (w_nextOpcode),
    .o_ctrl   (w_nextCtrl)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_opcode   <= OP_ADD;
      r_stepMode <= 1'b0;
      r_retired  <= '0;
      r_ctrl     <= '0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_nextState;
      r_opcode   <= w_nextOpcode;
      r_stepMode <= w_nextStepMode;
      r_ctrl     <= w_nextCtrl;
      r_busy     <= (w_nextState != ST_IDLE);
      if (r_ctrl.instrDone) r_retired <= r_retired + RET_W'(1);
    end
  end

  assign bus.IR_LOAD    = r_ctrl.irLoad;
  assign bus.PC_WRITE   = r_ctrl.pcWrite;
  assign bus.PC_SRC     = r_ctrl.pcSrc;
  assign bus.ALU_SRC    = r_ctrl.aluSrc;
  assign bus.MEM_READ   = r_ctrl.memRead;
  assign bus.MEM_WRITE  = r_ctrl.memWrite;
  assign bus.REG_WRITE  = r_ctrl.regWrite;
  assign bus.REG_DST    = r_ctrl.regDst;
  assign bus.MEM_TO_REG = r_ctrl.memToReg;
  assign bus.INSTR_DONE = r_ctrl.instrDone;
  assign bus.STATE      = r_state;
  assign bus.BUSY       = r_busy;
  assign bus.RETIRED    = r_retired;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Testbench: a free-running (AUTO_RUN=1) and a debug-controlled (AUTO_RUN=0) controller
// checked every cycle against a per-instruction phase-schedule reference model.
module tb_multicycle_ctrl;

  localparam int DONE_BIT = 9;

  logic CLK = 1'b0;
  logic RST;

  multicycle_ctrl_if #(.RET_W(8)) ifA ();
  multicycle_ctrl_if #(.RET_W(8)) ifM ();

  multicycle_ctrl #(.AUTO_RUN(1'b1), .RET_W(8)) dutA (
    .CLK (CLK),
    .RST (RST),
    .bus (ifA.master)
  );

  multicycle_ctrl #(.AUTO_RUN(1'b0), .RET_W(8)) dutM (
    .CLK (CLK),
    .RST (RST),
    .bus (ifM.master)
  );

  always #5 CLK = ~CLK;

  int          checkCount  = 0;
  int          passCount   = 0;
  int          doneCountA  = 0;
  bit          memReadSeenA = 1'b0;

  // Model: per instance, the list of expected phase vectors of the current instruction
  logic [13:0] plan [2][6];
  int          pIdx [2];
  bit          active [2];
  bit          stepMode [2];
  int          retExp [2];
  logic [13:0] expVec [2];

  // Vector: {state[2:0], busy, done, irLoad, pcWrite, pcSrc, aluSrc, memRead, memWrite, regWrite, regDst, memToReg}
  function automatic logic [13:0] mkVec(input logic [2:0] st, input logic [9:0] flags);
    return {st, (st != 3'd0), flags};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got === want) passCount++;
    else $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
  endtask

  // Flags order: done ir pw ps as mr mw rw rd m2r
  task automatic buildPlan(input int k, input logic [1:0] op);
    case (op)
      2'b00: begin
        plan[k][1] = mkVec(3'd2, 10'b0_0000_00000);
        plan[k][2] = mkVec(3'd3, 10'b0_0000_00000);
        plan[k][3] = mkVec(3'd5, 10'b1_0000_00110);
      end
      2'b01: begin
        plan[k][1] = mkVec(3'd2, 10'b0_0000_00000);
        plan[k][2] = mkVec(3'd3, 10'b0_0001_00000);
        plan[k][3] = mkVec(3'd4, 10'b0_0001_10000);
        plan[k][4] = mkVec(3'd5, 10'b1_0000_00101);
      end
      2'b10: begin
        plan[k][1] = mkVec(3'd2, 10'b0_0000_00000);
        plan[k][2] = mkVec(3'd3, 10'b0_0001_00000);
        plan[k][3] = mkVec(3'd4, 10'b1_0000_01000);
      end
      default: begin
        plan[k][1] = mkVec(3'd2, 10'b1_0110_00000);
      end
    endcase
  endtask

  task automatic modelStep(input int k, input bit rst, input bit run, input bit step, input logic [7:0] instr);
    if (rst) begin
      active[k]   = 1'b0;
      stepMode[k] = 1'b0;
      retExp[k]   = 0;
    end else if (!active[k]) begin
      if (run || step) begin
        active[k]   = 1'b1;
        stepMode[k] = !run && step;
        pIdx[k]     = 0;
      end
    end else if (plan[k][pIdx[k]][DONE_BIT]) begin
      retExp[k] = (retExp[k] + 1) % 256;
      if (run && !stepMode[k]) pIdx[k] = 0;
      else active[k] = 1'b0;
    end else begin
      if (pIdx[k] == 0) buildPlan(k, instr[7:6]);
      pIdx[k]++;
    end
    expVec[k] = active[k] ? plan[k][pIdx[k]] : 14'd0;
  endtask

  task automatic sampleAndCheck();
    logic [13:0] obsA;
    logic [13:0] obsM;
    obsA = {ifA.STATE, ifA.BUSY, ifA.INSTR_DONE, ifA.IR_LOAD, ifA.PC_WRITE, ifA.PC_SRC, ifA.ALU_SRC,
            ifA.MEM_READ, ifA.MEM_WRITE, ifA.REG_WRITE, ifA.REG_DST, ifA.MEM_TO_REG};
    obsM = {ifM.STATE, ifM.BUSY, ifM.INSTR_DONE, ifM.IR_LOAD, ifM.PC_WRITE, ifM.PC_SRC, ifM.ALU_SRC,
            ifM.MEM_READ, ifM.MEM_WRITE, ifM.REG_WRITE, ifM.REG_DST, ifM.MEM_TO_REG};
    if (ifA.INSTR_DONE) doneCountA++;
    if (ifA.MEM_READ) memReadSeenA = 1'b1;
    checkOutput("ctrlA", 32'(obsA), 32'(expVec[0]));
    checkOutput("retiredA", 32'(ifA.RETIRED), 32'(retExp[0]));
    checkOutput("ctrlM", 32'(obsM), 32'(expVec[1]));
    checkOutput("retiredM", 32'(ifM.RETIRED), 32'(retExp[1]));
  endtask

  task automatic applyStimulus(input bit rst, input bit runA, input bit stepA, input logic [7:0] instrA,
                               input bit runM, input bit stepM, input logic [7:0] instrM);
    RST       = rst;
    ifA.RUN   = runA;
    ifA.STEP  = stepA;
    ifA.INSTR = instrA;
    ifM.RUN   = runM;
    ifM.STEP  = stepM;
    ifM.INSTR = instrM;
    modelStep(0, rst, 1'b1, stepA, instrA);
    modelStep(1, rst, runM, stepM, instrM);
    @(posedge CLK);
    #1;
    sampleAndCheck();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [7:0] ia;
    bit         runM;
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 6; p++) plan[k][p] = 14'd0;
      plan[k][0]  = mkVec(3'd1, 10'b0_1100_00000);
      pIdx[k]     = 0;
      active[k]   = 1'b0;
      stepMode[k] = 1'b0;
      retExp[k]   = 0;
      expVec[k]   = 14'd0;
    end

    // Reset, then ADD/LW/SW/J on the free-running unit while the debug unit single-steps one ADD
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h1B, 1'b0, 1'b0, 8'h1B);
    for (int i = 0; i < 40; i++) begin
      ia = (i < 9) ? 8'h1B : (i < 19) ? 8'h45 : (i < 29) ? 8'h85 : 8'hC3;
      applyStimulus(1'b0, 1'b0, 1'b0, ia, 1'b0, (i == 0) || (i == 2), 8'h1B);
    end
    checkOutput("stepRetired", 32'(ifM.RETIRED), 32'd1);
    checkOutput("stepIdle", 32'(ifM.STATE), 32'd0);

    // Abort an LW in EXEC with reset
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'h45, 1'b0, 1'b0, 8'h1B);
    memReadSeenA = 1'b0;
    for (int i = 0; i < 10 && ifA.STATE != 3'd3; i++)
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h45, 1'b0, 1'b0, 8'h1B);
    checkOutput("reachExecA", 32'(ifA.STATE), 32'd3);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h45, 1'b0, 1'b0, 8'h1B);
    checkOutput("abortState", 32'(ifA.STATE), 32'd0);
    checkOutput("abortRetired", 32'(ifA.RETIRED), 32'd0);
    checkOutput("abortNoMemRead", 32'(memReadSeenA), 32'd0);

    // Randomized instructions, run/step toggling and occasional resets
    runM = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 19) == 0) runM = !runM;
      applyStimulus($urandom_range(0, 249) == 0, 1'($urandom), 1'($urandom), 8'($urandom),
                    runM, $urandom_range(0, 7) == 0, 8'($urandom));
    end

    // 256 back-to-back jumps: counter wraps to zero
    for (int i = 0; i < 2; i++) applyStimulus(1'b1, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 8'hC3);
    doneCountA = 0;
    for (int i = 0; i < 513; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'hC3, 1'b1, 1'b0, 8'hC3);
    checkOutput("wrapRetired", 32'(ifA.RETIRED), 32'd0);
    checkOutput("wrapDonePulses", 32'(doneCountA), 32'd256);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
